seq_det_ctrl: RTL
=================

Name: seq_det_ctrl

Overview:
Run controller for serial pattern detection on a one-bit input stream. Software or a parent FSM loads a pattern of 1..MAX_LEN bits, a match target and an idle timeout, then starts a run. The block accepts bits through a valid/ready handshake, detects the pattern in overlapping or non-overlapping mode, and counts matches. The run ends at the match target, at timeout, or on abort. It sits between the stimulus/bit source and the status logic that consumes match events.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..15)
CNT_W, 8, width of the match counter and the target
TO_W, 16, width of the idle-timeout counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cfg_we  in  1  config write strobe; honoured only in IDLE/DONE
cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received
cfg_len  in  4  pattern length
cfg_overlap  in  1  1 = overlapping detection, 0 = history cleared after each match
cfg_target  in  CNT_W  matches that end the run; 0 = unlimited
cfg_timeout  in  TO_W  idle cycles that end the run; 0 = disabled
start  in  1  begin a run (IDLE/DONE only)
abort  in  1  terminate a run (RUN only)
in_valid  in  1  input bit valid
in_bit  in  1  input bit
in_ready  out  1  combinational: state==RUN && !abort
match  out  1  registered one-cycle pulse per detected match
match_count  out  CNT_W  matches in the current/last run
busy  out  1  state==RUN
done  out  1  high in DONE
timed_out  out  1  in DONE: run ended by timeout
err_cfg  out  1  one-cycle pulse: start rejected, invalid config

Behaviour:
- Reset (synchronous, active-high, clock clk): state IDLE; all config registers, history, fill, counters and outputs cleared to 0; in_ready=0.
- Config: on cfg_we in IDLE/DONE, all cfg_* inputs are registered. cfg_we in RUN is ignored. Config is invalid if len==0 or len>MAX_LEN.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE + start:
  - Valid config: go to RUN; clear history, fill, match_count, idle counter and timed_out.
  - Invalid config: pulse err_cfg and stay in the current state.
- start together with cfg_we: the start uses the config already registered, not the one being written.
- Beat acceptance: a beat is in_valid && in_ready at a rising edge. On a beat:
  - hist <= {hist[MAX_LEN-2:0], in_bit}
  - fill <= min(fill+1, len)
  - idle counter <= 0
- Match condition: new fill == len and new hist[len-1:0] == pattern[len-1:0], evaluated on the post-shift value.
- On match, at the same edge:
  - match=1 for one cycle.
  - match_count increments, saturating at all-ones.
  - If cfg_overlap==0, fill <= 0 instead of the incremented value.
- Target reached: if target!=0 and the incremented count == target, go to DONE at that edge. Further bits are not accepted.
- Idle timeout: in RUN without a beat, the idle counter increments. When timeout!=0 and the counter reaches timeout-1, the next edge moves to DONE with timed_out=1.
- abort in RUN: go to IDLE at the next edge. The coincident beat is not accepted. match_count holds its value. abort outside RUN is ignored.
- Priority in RUN: abort > target reached > timeout.
- DONE: done=1, busy=0, in_ready=0, match_count held. Leave on start (new run) or cfg_we (go to IDLE).
- Latency: 0 cycles from beat edge to registered match/count update. The earliest match is on the len-th accepted beat after start.

Test Plan:
1. Overlap: load pattern 4'b1011, len 4, overlap 1, target 0, timeout 0; start; send bits 1,0,1,1,0,1,1 → match pulses on beats 4 and 7; match_count=2; busy stays 1.
2. Non-overlap: same pattern with overlap 0; stream 1,0,1,1,0,1,1 → single match on beat 4; count=1. Then stream 1,0,1,1,1,0,1,1 → 2 matches (beats 4 and 8).
3. Target and idle timeout:
   - Target 2, overlap 1, stream 1011011 → DONE at the edge of beat 7; in_ready=0 afterwards; done=1; timed_out=0.
   - Timeout 5 with no in_valid after start → DONE after 5 cycles; timed_out=1; count=0.
4. Abort and backpressure: in RUN, assert abort together with in_valid on the 3rd bit → bit not accepted; next state IDLE; count unchanged. cfg_we during RUN is ignored: a readback run uses the old pattern.
5. Config error: len 0, then len 9 with MAX_LEN=8; start → err_cfg pulses each time; state stays IDLE; busy=0.
6. Reset mid-run: assert reset after 2 matches → next cycle all outputs 0, state IDLE; a restart with the same config counts from 0.

Source files
------------

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: run controller for serial pattern detection on a 1-bit stream.
// Holds a loaded pattern/target/timeout, accepts bits over valid/ready during a
// run, and reports one registered match pulse per detected occurrence.
module seq_det_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int TO_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [3:0]         cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic [TO_W-1:0]    cfg_timeout,
  input  logic               start,
  input  logic               abort,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic               in_ready,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done,
  output logic               timed_out,
  output logic               err_cfg
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  localparam logic [3:0] LEN_MAX = 4'(MAX_LEN);

  state_t             state_reg, state_next;

  logic [MAX_LEN-1:0] pattern_reg;
  logic [3:0]         len_reg;
  logic               overlap_reg;
  logic [CNT_W-1:0]   target_reg;
  logic [TO_W-1:0]    timeout_reg;

  logic [MAX_LEN-1:0] hist_reg;
  logic [3:0]         fill_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [TO_W-1:0]    idle_reg;
  logic               match_reg;
  logic               timed_out_reg;
  logic               err_reg;

  logic               cfg_ok;
  logic               start_ok;
  logic               beat;
  logic [MAX_LEN-1:0] hist_shift;
  logic [MAX_LEN-1:0] len_mask;
  logic [3:0]         fill_inc;
  logic [CNT_W-1:0]   count_inc;
  logic               hit;
  logic               target_hit;
  logic               idle_expire;

  // Only the low len bits of history take part in the comparison.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
    assign len_mask[gi] = (4'(gi) < len_reg);
  end

  // Validity is judged on the registered config, so a coincident cfg_we
  // cannot influence the start it arrives with.
  assign cfg_ok      = (len_reg != 4'd0) && (len_reg <= LEN_MAX);
  assign start_ok    = start && cfg_ok;
  assign beat        = in_valid && in_ready;
  assign hist_shift  = {hist_reg[MAX_LEN-2:0], in_bit};
  assign fill_inc    = (fill_reg >= len_reg) ? len_reg : fill_reg + 4'd1;
  assign count_inc   = (&count_reg) ? count_reg : count_reg + CNT_W'(1);
  assign hit         = beat && (fill_inc == len_reg) &&
                       (((hist_shift ^ pattern_reg) & len_mask) == '0);
  assign target_hit  = hit && (target_reg != '0) && (count_inc == target_reg);
  assign idle_expire = !beat && (timeout_reg != '0) &&
                       (idle_reg == timeout_reg - TO_W'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic: in RUN, abort wins over target, target over timeout.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start_ok) state_next = ST_RUN;
      ST_RUN: begin
        if (abort)            state_next = ST_IDLE;
        else if (target_hit)  state_next = ST_DONE;
        else if (idle_expire) state_next = ST_DONE;
      end
      ST_DONE: begin
        if (start_ok)    state_next = ST_RUN;
        else if (cfg_we) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs; in_ready drops with abort so the aborting beat is lost.
  always_comb begin
    busy      = (state_reg == ST_RUN);
    done      = (state_reg == ST_DONE);
    in_ready  = (state_reg == ST_RUN) && !abort;
    timed_out = timed_out_reg && (state_reg == ST_DONE);
  end

  assign match       = match_reg;
  assign match_count = count_reg;
  assign err_cfg     = err_reg;

  // Config capture, history/fill tracking, match counting and idle timing.
  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_reg   <= '0;
      len_reg       <= '0;
      overlap_reg   <= 1'b0;
      target_reg    <= '0;
      timeout_reg   <= '0;
      hist_reg      <= '0;
      fill_reg      <= '0;
      count_reg     <= '0;
      idle_reg      <= '0;
      match_reg     <= 1'b0;
      timed_out_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      match_reg <= hit;
      err_reg   <= start && !cfg_ok && (state_reg != ST_RUN);
      if (state_reg != ST_RUN) begin
        if (start_ok) begin
          // An accepted start keeps the already-registered config for the run.
          hist_reg      <= '0;
          fill_reg      <= '0;
          count_reg     <= '0;
          idle_reg      <= '0;
          timed_out_reg <= 1'b0;
        end else if (cfg_we) begin
          pattern_reg <= cfg_pattern;
          len_reg     <= cfg_len;
          overlap_reg <= cfg_overlap;
          target_reg  <= cfg_target;
          timeout_reg <= cfg_timeout;
        end
      end else if (!abort) begin
        if (beat) begin
          hist_reg <= hist_shift;
          fill_reg <= (hit && !overlap_reg) ? 4'd0 : fill_inc;
          idle_reg <= '0;
          if (hit) count_reg <= count_inc;
        end else if (idle_expire) begin
          timed_out_reg <= 1'b1;
        end else begin
          idle_reg <= idle_reg + TO_W'(1);
        end
      end
    end
  end

endmodule
